command_sequencer: RTL and testbench

Parametrised game-command sequencer between the player source (bot or pad), the PRNG and the Tetris game engine. It buffers player actions in a small FIFO, injects gravity DOWN steps at a programmable period, and emits SPAWN beats carrying a random shape index. It reacts to piece-touch and game-over events and presents every command as {action, data} on a valid/ready handshake to the engine.

---
 rtl/tetris_pkg.sv | 26 ++
 rtl/cmd_fifo.sv | 51 +++++
 rtl/command_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_command_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris command path: action codes, sequencer
// states and the default block parameters.
package tetris_pkg;

  // Action codes carried in the upper half of every command beat
  localparam int ACT_NOP    = 0;
  localparam int ACT_DOWN   = 1;
  localparam int ACT_LEFT   = 2;
  localparam int ACT_RIGHT  = 3;
  localparam int ACT_ROTATE = 4;
  localparam int ACT_SPAWN  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_PLAY,
    ST_LOCK,
    ST_OVER
  } state_t;

  localparam int DEF_WIDTH          = 8;
  localparam int DEF_SHAPE_COUNT    = 7;
  localparam int DEF_GRAVITY_PERIOD = 16;
  localparam int DEF_CMD_DEPTH      = 4;

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO buffering player actions. The head entry is visible
// on rdata whenever the FIFO is not empty; flush empties it in one cycle.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush wins over a same-cycle push or pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write, data only so no reset
  always_ff @(posedge clk) begin
    if (push && !full && !flush)
      mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/command_sequencer.sv
// Game-command sequencer: merges buffered player moves, gravity DOWN steps and
// SPAWN beats into one {action, data} stream toward the game engine, and
// tracks the piece lifecycle through spawn, play, lock and game over.
module command_sequencer import tetris_pkg::*; #(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int SHAPE_COUNT    = DEF_SHAPE_COUNT,
  parameter int GRAVITY_PERIOD = DEF_GRAVITY_PERIOD,
  parameter int CMD_DEPTH      = DEF_CMD_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   player_cmd,
  input  logic               player_valid,
  output logic               player_ready,
  input  logic [WIDTH-1:0]   prng_data,
  output logic               prng_en,
  input  logic               is_touch,
  input  logic               is_lose,
  output logic [2*WIDTH-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               game_over
);

  localparam int               GW        = $clog2(GRAVITY_PERIOD);
  localparam logic [GW-1:0]    GRAV_LAST = GW'(GRAVITY_PERIOD - 1);
  localparam logic [WIDTH-1:0] SHAPE_N   = WIDTH'(SHAPE_COUNT);
  localparam logic [WIDTH-1:0] MOVE_DATA = WIDTH'(1);

  function automatic logic [2*WIDTH-1:0] beat(input logic [WIDTH-1:0] act,
                                               input logic [WIDTH-1:0] d);
    return {act, d};
  endfunction

  function automatic logic [2*WIDTH-1:0] spawn_beat(input logic [WIDTH-1:0] r);
    return beat(WIDTH'(ACT_SPAWN), r % SHAPE_N);
  endfunction

  function automatic logic is_move(input logic [WIDTH-1:0] c);
    return (c == WIDTH'(ACT_DOWN))  || (c == WIDTH'(ACT_LEFT)) ||
           (c == WIDTH'(ACT_RIGHT)) || (c == WIDTH'(ACT_ROTATE));
  endfunction

  state_t             state;
  logic [GW-1:0]      grav_cnt;
  logic               pending_down;
  logic               touch_pending;

  logic [WIDTH-1:0]   fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_flush;

  logic               outstanding;
  logic               accept;
  logic               touch_lock;
  logic               slot;
  logic               issue_vld;
  logic [2*WIDTH-1:0] issue_data;

  assign player_ready = !fifo_full && (state != ST_OVER);
  assign fifo_push    = player_valid && player_ready;
  assign fifo_flush   = (state == ST_LOCK) || (state == ST_OVER);
  assign accept       = out_valid && out_ready;
  assign outstanding  = out_valid && !out_ready;

  cmd_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (fifo_push),
    .wdata (player_cmd),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-beat selection: gravity first, then FIFO head; non-move codes are
  // popped without producing a beat. The output slot may also be refilled in
  // the cycle the SPAWN beat is accepted so play starts without a bubble.
  always_comb begin
    touch_lock = (is_touch || touch_pending) && !outstanding;
    slot       = 1'b0;
    if (state == ST_PLAY)
      slot = !is_lose && !touch_lock && !outstanding;
    else if (state == ST_SPAWN)
      slot = !is_lose && accept;
    fifo_pop   = slot && !pending_down && !fifo_empty;
    issue_vld  = slot && (pending_down || (!fifo_empty && is_move(fifo_head)));
    issue_data = pending_down ? beat(WIDTH'(ACT_DOWN), MOVE_DATA)
                              : beat(fifo_head, MOVE_DATA);
  end

  // Sequencer FSM with registered outputs and gravity timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      out_valid     <= 1'b0;
      out_data      <= '0;
      prng_en       <= 1'b0;
      game_over     <= 1'b0;
      grav_cnt      <= '0;
      pending_down  <= 1'b0;
      touch_pending <= 1'b0;
    end else begin
      prng_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_SPAWN;
            out_valid <= 1'b1;
            out_data  <= spawn_beat(prng_data);
          end
        end
        ST_SPAWN: begin
          if (is_lose) begin
            state     <= ST_OVER;
            out_valid <= 1'b0;
            game_over <= 1'b1;
          end else if (accept) begin
            state     <= ST_PLAY;
            prng_en   <= 1'b1;
            grav_cnt  <= '0;
            out_valid <= issue_vld;
            if (issue_vld)
              out_data <= issue_data;
          end
        end
        ST_PLAY: begin
          grav_cnt <= (grav_cnt == GRAV_LAST) ? '0 : grav_cnt + 1'b1;
          if (is_lose) begin
            state     <= ST_OVER;
            out_valid <= 1'b0;
            game_over <= 1'b1;
          end else if (touch_lock) begin
            state     <= ST_LOCK;
            out_valid <= 1'b0;
          end else if (is_touch) begin
            touch_pending <= 1'b1;
          end else if (!outstanding) begin
            out_valid <= issue_vld;
            if (issue_vld)
              out_data <= issue_data;
            if (pending_down)
              pending_down <= 1'b0;
          end
          // A new gravity request overrides a same-cycle consume
          if (grav_cnt == GRAV_LAST)
            pending_down <= 1'b1;
        end
        ST_LOCK: begin
          pending_down  <= 1'b0;
          touch_pending <= 1'b0;
          state         <= ST_SPAWN;
          out_valid     <= 1'b1;
          out_data      <= spawn_beat(prng_data);
        end
        ST_OVER: begin
          pending_down  <= 1'b0;
          touch_pending <= 1'b0;
          if (start) begin
            state     <= ST_SPAWN;
            game_over <= 1'b0;
            out_valid <= 1'b1;
            out_data  <= spawn_beat(prng_data);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_command_sequencer.sv
// Directed bench for command_sequencer with default parameters.
module tb_command_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  player_cmd;
  logic        player_valid;
  logic        player_ready;
  logic [7:0]  prng_data;
  logic        prng_en;
  logic        is_touch;
  logic        is_lose;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        game_over;

  command_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .player_cmd   (player_cmd),
    .player_valid (player_valid),
    .player_ready (player_ready),
    .prng_data    (prng_data),
    .prng_en      (prng_en),
    .is_touch     (is_touch),
    .is_lose      (is_lose),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        start;
    logic        pv;
    logic [7:0]  cmd;
    logic [7:0]  prng;
    logic        touch;
    logic        lose;
    logic        ordy;
    logic        ev;
    logic [15:0] ed;
    logic        epen;
    logic        ego;
    logic        epr;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;
  int cycle   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // {valid, data (only meaningful while valid), prng_en, game_over, player_ready}
  function automatic logic [31:0] snap();
    return {12'h0, out_valid, (out_valid ? out_data : 16'h0), prng_en, game_over, player_ready};
  endfunction

  function automatic logic [31:0] expv(input logic ev, input logic [15:0] ed,
                                       input logic epen, input logic ego, input logic epr);
    return {12'h0, ev, (ev ? ed : 16'h0), epen, ego, epr};
  endfunction

  function automatic vec_t v(input logic st, input logic pv, input logic [7:0] cmd,
                             input logic [7:0] prng, input logic touch, input logic lose,
                             input logic ordy, input logic ev, input logic [15:0] ed,
                             input logic epen, input logic ego, input logic epr);
    vec_t r;
    r = '{st, pv, cmd, prng, touch, lose, ordy, ev, ed, epen, ego, epr};
    return r;
  endfunction

  task automatic wait_down(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (out_valid && out_data == 16'h0101) ok = 1'b1;
    end
  endtask

  vec_t vecs [25];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit ok1, ok2;
    int c1, c2;

    // Inputs in step i, outputs expected right after that cycle's edge
    vecs[0] = v(1,0,8'd0,8'd10,0,0,0, 1,16'h0503,0,0,1);
    for (int i = 1; i <= 5; i++)
      vecs[i] = v(0,0,8'd0,8'd20,0,0,0, 1,16'h0503,0,0,1);
    vecs[6]  = v(0,0,8'd0,8'd20,0,0,1, 0,16'h0000,1,0,1);
    vecs[7]  = v(0,1,8'd2,8'd20,0,0,1, 0,16'h0000,0,0,1);
    vecs[8]  = v(0,1,8'd3,8'd20,0,0,1, 1,16'h0201,0,0,1);
    vecs[9]  = v(0,1,8'd9,8'd20,0,0,1, 1,16'h0301,0,0,1);
    vecs[10] = v(0,1,8'd4,8'd20,0,0,1, 0,16'h0000,0,0,1);
    vecs[11] = v(0,0,8'd0,8'd20,0,0,1, 1,16'h0401,0,0,1);
    vecs[12] = v(0,0,8'd0,8'd20,0,0,0, 1,16'h0401,0,0,1);
    for (int i = 13; i <= 15; i++)
      vecs[i] = v(0,1,8'd2,8'd20,0,0,0, 1,16'h0401,0,0,1);
    vecs[16] = v(0,1,8'd2,8'd20,0,0,0, 1,16'h0401,0,0,0);
    vecs[17] = v(0,1,8'd2,8'd20,0,0,0, 1,16'h0401,0,0,0);
    for (int i = 18; i <= 22; i++)
      vecs[i] = v(0,0,8'd0,8'd20,0,0,0, 1,16'h0401,0,0,0);
    vecs[23] = v(0,0,8'd0,8'd20,0,0,1, 1,16'h0101,0,0,0);
    vecs[24] = v(0,0,8'd0,8'd20,0,0,1, 1,16'h0201,0,0,1);

    rst = 1'b1; start = 0; player_cmd = 0; player_valid = 0;
    prng_data = 0; is_touch = 0; is_lose = 0; out_ready = 0;
    #12;
    chk("reset_state", {12'h0, out_valid, out_data, prng_en, game_over, player_ready},
        32'h0000_0001);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      start = vecs[i].start; player_valid = vecs[i].pv; player_cmd = vecs[i].cmd;
      prng_data = vecs[i].prng; is_touch = vecs[i].touch; is_lose = vecs[i].lose;
      out_ready = vecs[i].ordy;
      tick();
      chk($sformatf("vec%0d", i), snap(),
          expv(vecs[i].ev, vecs[i].ed, vecs[i].epen, vecs[i].ego, vecs[i].epr));
    end

    // Gravity: two consecutive DOWN beats 16 cycles apart
    player_valid = 0; out_ready = 1;
    wait_down(ok1);
    c1 = cycle;
    chk("grav_first_found", {31'h0, ok1}, 32'h1);
    wait_down(ok2);
    c2 = cycle;
    chk("grav_period", c2 - c1, 32'd16);

    // Touch while DOWN is stalled; RIGHT pushed meanwhile must be flushed
    out_ready = 0; is_touch = 1; player_valid = 1; player_cmd = 8'd3;
    tick();
    chk("touch_stall_hold", snap(), expv(1, 16'h0101, 0, 0, 1));
    is_touch = 0; player_valid = 0;
    tick();
    chk("touch_stall_hold2", snap(), expv(1, 16'h0101, 0, 0, 1));
    out_ready = 1; prng_data = 8'd12;
    tick();
    chk("touch_to_lock", snap(), expv(0, 16'h0, 0, 0, 1));
    tick();
    chk("lock_spawn", snap(), expv(1, 16'h0505, 0, 0, 1));
    tick();
    chk("spawn_accept_flushed", snap(), expv(0, 16'h0, 1, 0, 1));

    // Touch with nothing outstanding: LOCK next cycle, SPAWN beat after
    is_touch = 1; prng_data = 8'd14;
    tick();
    chk("touch_idle_lock", snap(), expv(0, 16'h0, 0, 0, 1));
    is_touch = 0;
    tick();
    chk("touch_idle_spawn", snap(), expv(1, 16'h0500, 0, 0, 1));
    tick();
    chk("spawn3_accept", snap(), expv(0, 16'h0, 1, 0, 1));

    // Lose with a stalled beat, then restart from OVER
    out_ready = 0; player_valid = 1; player_cmd = 8'd2;
    tick();
    player_valid = 0;
    tick();
    chk("lose_pre_beat", snap(), expv(1, 16'h0201, 0, 0, 1));
    is_lose = 1;
    tick();
    chk("lose_over", snap(), expv(0, 16'h0, 0, 1, 0));
    is_lose = 0; player_valid = 1;
    tick();
    chk("over_hold", snap(), expv(0, 16'h0, 0, 1, 0));
    player_valid = 0; start = 1; prng_data = 8'd13;
    tick();
    chk("over_restart", snap(), expv(1, 16'h0506, 0, 0, 1));
    start = 0; out_ready = 1;
    tick();
    chk("restart_accept", snap(), expv(0, 16'h0, 1, 0, 1));

    // Asynchronous reset in the middle of a stalled PLAY beat
    out_ready = 0; player_valid = 1; player_cmd = 8'd3;
    tick();
    player_valid = 0;
    tick();
    chk("rst_pre_beat", snap(), expv(1, 16'h0301, 0, 0, 1));
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", {12'h0, out_valid, out_data, prng_en, game_over, player_ready},
        32'h0000_0001);
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rst_idle_stays", snap(), expv(0, 16'h0, 0, 0, 1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
